// File: rtl/bin_to_bcd_seq_if.sv
// Start/done bus between a binary source and the sequential binary-to-BCD converter.
// Optional port: neg, present only when BIN_TO_BCD_SIGNED_EN is defined.
interface bin_to_bcd_seq_if #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
);
    // Handshake: the source raises start with bin valid; the converter takes it on
    // the first edge where it is idle (busy=0, done=0), raises busy for the
    // conversion, then pulses done for one cycle as bcd/ovf update. start is
    // ignored while busy or done is high. bcd/ovf hold their value until the next done.
    logic                  start;
    logic [BIN_W-1:0]      bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  ovf;
`ifdef BIN_TO_BCD_SIGNED_EN
    logic                  neg;
`endif
    logic [1:0]            fsm_state;

`ifdef BIN_TO_BCD_SIGNED_EN
    modport master (output start, bin, input busy, done, bcd, ovf, neg, fsm_state);
    modport slave  (input start, bin, output busy, done, bcd, ovf, neg, fsm_state);
`else
    modport master (output start, bin, input busy, done, bcd, ovf, fsm_state);
    modport slave  (input start, bin, output busy, done, bcd, ovf, fsm_state);
`endif
endinterface

// File: rtl/bin_to_bcd_seq.sv
// Sequential double-dabble binary-to-BCD converter, one input bit per clock.
// Optional two's-complement input with sign output: define BIN_TO_BCD_SIGNED_EN.
module bin_to_bcd_seq #(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input logic           clk,
    input logic           rst,
    bin_to_bcd_seq_if.slave bus
);
    localparam int BCD_W = 4 * DIGITS;
    localparam int CNT_W = $clog2(BIN_W + 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]       state;
    logic [BIN_W-1:0] shreg;
    logic [BCD_W-1:0] work;
    logic [BCD_W-1:0] work_adj;
    logic [BCD_W-1:0] work_nxt;
    logic [BIN_W-1:0] sh_nxt;
    logic             carry;
    logic [CNT_W-1:0] cnt;
    logic             sticky;
    logic             busy_r;
    logic             done_r;
    logic [BCD_W-1:0] bcd_r;
    logic             ovf_r;
    logic [BIN_W-1:0] load_val;

    // Add-3 correction on every digit before the shift; carries never cross digits.
    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        logic [3:0] d;
        assign d = work[4*i +: 4];
        assign work_adj[4*i +: 4] = (d >= 4'd5) ? d + 4'd3 : d;
    end

    assign carry    = work_adj[BCD_W-1];
    assign work_nxt = {work_adj[BCD_W-2:0], shreg[BIN_W-1]};
    assign sh_nxt   = {shreg[BIN_W-2:0], 1'b0};

`ifdef BIN_TO_BCD_SIGNED_EN
    logic load_neg;
    logic neg_work;
    logic neg_r;
    // Negating in BIN_W bits maps the most negative value onto 2^(BIN_W-1), which
    // is exactly its magnitude when read as unsigned.
    assign load_neg = bus.bin[BIN_W-1];
    assign load_val = load_neg ? ({BIN_W{1'b0}} - bus.bin) : bus.bin;
    assign bus.neg  = neg_r;
`else
    assign load_val = bus.bin;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= S_IDLE;
            shreg  <= '0;
            work   <= '0;
            cnt    <= '0;
            sticky <= 1'b0;
            busy_r <= 1'b0;
            done_r <= 1'b0;
            bcd_r  <= '0;
            ovf_r  <= 1'b0;
`ifdef BIN_TO_BCD_SIGNED_EN
            neg_work <= 1'b0;
            neg_r    <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    done_r <= 1'b0;
                    if (bus.start) begin
                        shreg  <= load_val;
                        work   <= '0;
                        sticky <= 1'b0;
                        cnt    <= CNT_W'(BIN_W);
                        busy_r <= 1'b1;
                        state  <= S_SHIFT;
`ifdef BIN_TO_BCD_SIGNED_EN
                        neg_work <= load_neg;
`endif
                    end
                end
                S_SHIFT: begin
                    shreg  <= sh_nxt;
                    work   <= work_nxt;
                    sticky <= sticky | carry;
                    cnt    <= cnt - CNT_W'(1);
                    // Last bit: publish the post-shift register, including this edge's carry.
                    if (cnt == CNT_W'(1)) begin
                        bcd_r  <= work_nxt;
                        ovf_r  <= sticky | carry;
                        done_r <= 1'b1;
                        busy_r <= 1'b0;
                        state  <= S_DONE;
`ifdef BIN_TO_BCD_SIGNED_EN
                        neg_r  <= neg_work;
`endif
                    end
                end
                S_DONE: begin
                    done_r <= 1'b0;
                    state  <= S_IDLE;
                end
                default: begin
                    done_r <= 1'b0;
                    busy_r <= 1'b0;
                    state  <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.busy      = busy_r;
    assign bus.done      = done_r;
    assign bus.bcd       = bcd_r;
    assign bus.ovf       = ovf_r;
    assign bus.fsm_state = state;
endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Bench for bin_to_bcd_seq: three configurations (8b/3 digits, 8b/2 digits, 12b/4 digits)
// checked against a decimal reference model through per-instance expected queues.
module tb_bin_to_bcd_seq;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    bin_to_bcd_seq_if #(.BIN_W(8),  .DIGITS(3)) bus_a ();
    bin_to_bcd_seq_if #(.BIN_W(8),  .DIGITS(2)) bus_b ();
    bin_to_bcd_seq_if #(.BIN_W(12), .DIGITS(4)) bus_c ();

    bin_to_bcd_seq #(.BIN_W(8),  .DIGITS(3)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    bin_to_bcd_seq #(.BIN_W(8),  .DIGITS(2)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));
    bin_to_bcd_seq #(.BIN_W(12), .DIGITS(4)) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

`ifdef BIN_TO_BCD_SIGNED_EN
    wire neg_a = bus_a.neg;
    wire neg_b = bus_b.neg;
    wire neg_c = bus_c.neg;
`else
    wire neg_a = 1'b0;
    wire neg_b = 1'b0;
    wire neg_c = 1'b0;
`endif

    int vectors     = 0;
    int miscompares = 0;

    // Entry layout: {neg, ovf, bcd zero-extended to 16 bits}
    logic [17:0] exp_q_a[$];
    logic [17:0] exp_q_b[$];
    logic [17:0] exp_q_c[$];

    function automatic int bw(input int w);
        return (w == 2) ? 12 : 8;
    endfunction

    function automatic int dg(input int w);
        return (w == 0) ? 3 : (w == 1) ? 2 : 4;
    endfunction

    // Decimal reference: divide/modulo by powers of ten, no shift-and-add.
    function automatic logic [17:0] model(input logic [11:0] v, input int w);
        int mag;
        int p;
        logic neg;
        logic o;
        logic [15:0] b;
        mag = int'(v) & ((1 << bw(w)) - 1);
        neg = 1'b0;
`ifdef BIN_TO_BCD_SIGNED_EN
        if (mag >= (1 << (bw(w) - 1))) begin
            neg = 1'b1;
            mag = (1 << bw(w)) - mag;
        end
`endif
        b = '0;
        p = 1;
        for (int i = 0; i < dg(w); i++) begin
            b[4*i +: 4] = 4'((mag / p) % 10);
            p = p * 10;
        end
        o = (mag >= p);
        return {neg, o, b};
    endfunction

    function automatic logic get_busy(input int w);
        case (w)
            0: return bus_a.busy;
            1: return bus_b.busy;
            default: return bus_c.busy;
        endcase
    endfunction

    function automatic logic get_done(input int w);
        case (w)
            0: return bus_a.done;
            1: return bus_b.done;
            default: return bus_c.done;
        endcase
    endfunction

    function automatic logic [16:0] get_res(input int w);
        case (w)
            0: return {bus_a.ovf, 16'(bus_a.bcd)};
            1: return {bus_b.ovf, 16'(bus_b.bcd)};
            default: return {bus_c.ovf, bus_c.bcd};
        endcase
    endfunction

    task automatic drive(input int w, input logic s, input logic [11:0] v);
        case (w)
            0: begin bus_a.start = s; bus_a.bin = v[7:0]; end
            1: begin bus_b.start = s; bus_b.bin = v[7:0]; end
            default: begin bus_c.start = s; bus_c.bin = v; end
        endcase
    endtask

    task automatic push(input int w, input logic [11:0] v);
        case (w)
            0: exp_q_a.push_back(model(v, w));
            1: exp_q_b.push_back(model(v, w));
            default: exp_q_c.push_back(model(v, w));
        endcase
    endtask

    // Scoreboard: every done pulse pops one expected result.
    always @(negedge clk) begin
        logic [17:0] e;
        logic [17:0] act;
        if (bus_a.done === 1'b1) begin
            act = {neg_a, bus_a.ovf, 16'(bus_a.bcd)};
            vectors++;
            if (exp_q_a.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_done_a got %h with empty queue", act);
            end else begin
                e = exp_q_a.pop_front();
                if (act !== e) begin
                    miscompares++;
                    $display("FAIL result_a got %h expected %h", act, e);
                end
            end
        end
        if (bus_b.done === 1'b1) begin
            act = {neg_b, bus_b.ovf, 16'(bus_b.bcd)};
            vectors++;
            if (exp_q_b.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_done_b got %h with empty queue", act);
            end else begin
                e = exp_q_b.pop_front();
                if (act !== e) begin
                    miscompares++;
                    $display("FAIL result_b got %h expected %h", act, e);
                end
            end
        end
        if (bus_c.done === 1'b1) begin
            act = {neg_c, bus_c.ovf, bus_c.bcd};
            vectors++;
            if (exp_q_c.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_done_c got %h with empty queue", act);
            end else begin
                e = exp_q_c.pop_front();
                if (act !== e) begin
                    miscompares++;
                    $display("FAIL result_c got %h expected %h", act, e);
                end
            end
        end
    end

    // One conversion with latency, busy and hold checks; result goes through the scoreboard.
    task automatic run_conv(input int w, input logic [11:0] v);
        logic [16:0] held;
        bit busy_ok;
        bit held_ok;
        int c;
        @(negedge clk);
        held = get_res(w);
        drive(w, 1'b1, v);
        push(w, v);
        @(negedge clk);
        drive(w, 1'b0, v);
        vectors++;
        if (get_busy(w) !== 1'b1) begin
            miscompares++;
            $display("FAIL busy_after_accept inst %0d got %b expected 1", w, get_busy(w));
        end
        busy_ok = 1'b1;
        held_ok = 1'b1;
        for (c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (get_done(w) === 1'b1) break;
            if (get_busy(w) !== 1'b1) busy_ok = 1'b0;
            if (get_res(w) !== held) held_ok = 1'b0;
        end
        vectors++;
        if (c != bw(w)) begin
            miscompares++;
            $display("FAIL latency inst %0d got %0d edges expected %0d", w, c, bw(w));
            return;
        end
        vectors++;
        if (!busy_ok || !held_ok) begin
            miscompares++;
            $display("FAIL busy_hold inst %0d busy_ok %0b held_ok %0b expected 1 1", w, busy_ok, held_ok);
        end
        vectors++;
        if (get_busy(w) !== 1'b0) begin
            miscompares++;
            $display("FAIL busy_at_done inst %0d got %b expected 0", w, get_busy(w));
        end
        @(negedge clk);
        vectors++;
        if (get_done(w) !== 1'b0) begin
            miscompares++;
            $display("FAIL done_pulse_width inst %0d got %b expected 0", w, get_done(w));
        end
    endtask

    task automatic test_reset();
        int c;
        rst = 1'b1;
        drive(0, 1'b0, 12'd0);
        drive(1, 1'b0, 12'd0);
        drive(2, 1'b0, 12'd0);
        repeat (2) @(negedge clk);
        vectors++;
        if ({bus_a.busy, bus_a.done, bus_a.ovf, bus_a.bcd} !== 15'd0) begin
            miscompares++;
            $display("FAIL reset_state_a got %h expected 0", {bus_a.busy, bus_a.done, bus_a.ovf, bus_a.bcd});
        end
        vectors++;
        if ({bus_c.busy, bus_c.done, bus_c.ovf, bus_c.bcd} !== 19'd0) begin
            miscompares++;
            $display("FAIL reset_state_c got %h expected 0", {bus_c.busy, bus_c.done, bus_c.ovf, bus_c.bcd});
        end
        // Release reset and request a conversion on the same cycle.
        rst = 1'b0;
        drive(0, 1'b1, 12'd37);
        push(0, 12'd37);
        @(negedge clk);
        drive(0, 1'b0, 12'd37);
        vectors++;
        if (bus_a.busy !== 1'b1) begin
            miscompares++;
            $display("FAIL first_start_after_reset got busy %b expected 1", bus_a.busy);
        end
        for (c = 0; c < 40 && (bus_a.busy || bus_a.done); c++) @(negedge clk);
        vectors++;
        if (c >= 40) begin
            miscompares++;
            $display("FAIL first_conv_timeout got %0d cycles expected < 40", c);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        drive(0, 1'b1, 12'd200);
        @(negedge clk);
        drive(0, 1'b0, 12'd200);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        vectors++;
        if ({bus_a.busy, bus_a.done, bus_a.ovf, bus_a.bcd} !== 15'd0) begin
            miscompares++;
            $display("FAIL reset_mid_abort got %h expected 0", {bus_a.busy, bus_a.done, bus_a.ovf, bus_a.bcd});
        end
        @(negedge clk);
        rst = 1'b0;
        repeat (12) @(negedge clk);
        vectors++;
        if (bus_a.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL reset_mid_idle got busy %b expected 0", bus_a.busy);
        end
        run_conv(0, 12'd0);
    endtask

    task automatic test_values();
        run_conv(0, 12'd255);
        run_conv(0, 12'd99);
        run_conv(0, 12'd1);
    endtask

    task automatic test_start_held();
        int first;
        int second;
        first  = -1;
        second = -1;
        @(negedge clk);
        drive(0, 1'b1, 12'd128);
        push(0, 12'd128);
        for (int k = 1; k <= 40 && second < 0; k++) begin
            @(negedge clk);
            if (k == 3) begin
                drive(0, 1'b1, 12'd1);
                push(0, 12'd1);
            end
            if (bus_a.done === 1'b1) begin
                if (first < 0) first = k;
                else begin
                    second = k;
                    drive(0, 1'b0, 12'd1);
                end
            end
        end
        drive(0, 1'b0, 12'd1);
        vectors++;
        if (first != 9) begin
            miscompares++;
            $display("FAIL held_first_done got cycle %0d expected 9", first);
        end
        vectors++;
        if (second - first != 10) begin
            miscompares++;
            $display("FAIL held_period got %0d expected 10", second - first);
        end
        repeat (2) @(negedge clk);
        vectors++;
        if (bus_a.busy !== 1'b0) begin
            miscompares++;
            $display("FAIL held_release got busy %b expected 0", bus_a.busy);
        end
    endtask

    task automatic test_overflow();
        run_conv(1, 12'd200);
        run_conv(1, 12'd99);
        run_conv(1, 12'd100);
        run_conv(0, 12'd0);
    endtask

    task automatic test_wide();
        run_conv(2, 12'd4095);
        run_conv(2, 12'd1234);
        run_conv(2, 12'd9);
    endtask

`ifdef BIN_TO_BCD_SIGNED_EN
    task automatic test_signed();
        run_conv(0, 12'h080);
        run_conv(0, 12'h0FF);
        run_conv(0, 12'd127);
        run_conv(2, 12'h800);
    endtask
`endif

    task automatic test_back_to_back();
        for (int i = 0; i < 6; i++) begin
            run_conv(0, 12'($urandom_range(0, 255)));
            run_conv(1, 12'($urandom_range(0, 255)));
            run_conv(2, 12'($urandom_range(0, 4095)));
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog expired at %0t expected completion", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_reset_mid();
        test_values();
        test_start_held();
        test_overflow();
        test_wide();
`ifdef BIN_TO_BCD_SIGNED_EN
        test_signed();
`endif
        test_back_to_back();
        repeat (4) @(negedge clk);
        vectors++;
        if (exp_q_a.size() + exp_q_b.size() + exp_q_c.size() != 0) begin
            miscompares++;
            $display("FAIL leftover_expected got %0d entries expected 0",
                     exp_q_a.size() + exp_q_b.size() + exp_q_c.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/bin_to_bcd_seq.md
Name: bin_to_bcd_seq

Overview:
- Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one bit per clock.
- Sits directly upstream of the team's BCD digit adders. It turns binary operands (switch inputs, counter values) into packed BCD digits for the BCD add chain.
- Uses a start/done handshake. The output register holds the last result.

Parameters:
- BIN_W, 8, width of the binary input in bits (>=2).
- DIGITS, 3, number of BCD output digits. Output width is 4*DIGITS.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- start  input  1  request a conversion. Sampled only in IDLE.
- bin  input  BIN_W  unsigned binary value. Captured on the edge that accepts start.
- busy  output  1  high while a conversion is in progress.
- done  output  1  one-cycle pulse when bcd/ovf are updated.
- bcd  output  4*DIGITS  packed BCD result. Digit 0 is in bits [3:0].
- ovf  output  1  result did not fit in DIGITS digits. Valid with done, then held.

Behaviour:
- Reset (async, rst=1): state=IDLE; busy=0, done=0, bcd=0, ovf=0. Working registers cleared.
  - Reset mid-conversion aborts with no done pulse.
  - First start is accepted on the first edge after rst deasserts.
- States: IDLE, SHIFT, DONE.
- IDLE:
  - start=1 at edge 0: capture bin into a shift register, clear the BCD working register and the sticky ovf, load bit counter = BIN_W, go to SHIFT, busy=1.
  - start=0: stay in IDLE.
- SHIFT (edges 1..BIN_W), each edge:
  - Every working digit >=5 gets +3 (4-bit, no carry out of the digit).
  - Then the concatenation {BCD working, shift reg} shifts left by 1. The binary MSB enters BCD bit 0.
  - Any 1 shifted out of the top BCD bit sets sticky ovf.
  - Counter decrements.
  - On the edge where the counter reaches 0 (edge BIN_W): bcd <= working register (post-shift), ovf <= sticky ovf, done=1, busy=0, state=DONE.
- DONE: lasts exactly one cycle, done=1. Next edge: done=0, state=IDLE unconditionally.
- start is ignored in SHIFT and DONE; no queuing.
- Latency: done is high in the cycle following edge BIN_W after start is accepted.
- Throughput: one conversion per BIN_W+2 cycles.
- bin changes after capture have no effect.
- bcd/ovf change only on the done edge. They are held otherwise, including while busy.
- Overflow: when ovf=1, bcd holds the low DIGITS digits of the true result (value mod 10^DIGITS). Each digit is still a valid BCD digit (0-9).
- Digits never exceed 9 when ovf=0.
- BIN_W=1 is unsupported.

Optional Feature:
- Macro: BIN_TO_BCD_SIGNED_EN.
- Defined:
  - bin is two's complement. Extra output port neg (1 bit, reset 0) is updated with bcd on the done edge.
  - On capture, if bin[BIN_W-1]=1, the shift register loads the magnitude (-bin, computed in BIN_W bits) and sets neg.
  - Most negative value: -2^(BIN_W-1) converts to magnitude 2^(BIN_W-1) correctly.
  - Latency is unchanged.
- Undefined: no neg port. bin is unsigned as above.

Test Plan:
- Reset mid-conversion: start with bin=8'd200, assert rst after edge 3 -> busy=0, bcd=0, ovf=0, no done pulse. Then start bin=8'd0 -> done after 8 edges, bcd=12'h000, ovf=0.
- Values and latency: bin=8'd255 -> bcd=12'h255, and bin=8'd99 -> bcd=12'h099. Each with done high exactly one cycle, 8 edges after start is accepted; busy high during edges 0..7.
- Start ignored: start held high continuously with bin=8'd128 -> bcd=12'h128, conversions every 10 cycles. A bin change to 8'd1 during SHIFT has no effect on the current result.
- Overflow: DIGITS=2, bin=8'd200 -> ovf=1, bcd=8'h00. Then bin=8'd99 -> ovf=0, bcd=8'h99.
- Wider config: BIN_W=12, DIGITS=4, bin=12'd4095 -> bcd=16'h4095, done 12 edges after acceptance.
- Signed (BIN_TO_BCD_SIGNED_EN): bin=8'h80 -> neg=1, bcd=12'h128. bin=8'hFF -> neg=1, bcd=12'h001. bin=8'd127 -> neg=0, bcd=12'h127.
